// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the two cache-side request/response channels and the main-memory
//   block port that mem_arbiter multiplexes between them.
//   Parameters: Word_Size (bits per word), Block_Size (words per block).
//   Signals:
//     I-cache : ic_read, ic_Addr -> ic_Data, ic_ready
//     D-cache : dc_read, dc_write, dc_Addr, dc_Wdata -> dc_Rdata, dc_ready
//     Memory  : Addr_Mem, read_Mem, write_Mem, Data_Mem_wr -> Data_Mem_rd, ready_mem
//     Status  : busy
//   Modports: slave  - the arbiter's view (serves caches, drives memory)
//             master - the environment's view (caches and memory)
interface mem_arbiter_if #(
  parameter int Word_Size  = 32,
  parameter int Block_Size = 4
);
  localparam int BLK_W = Word_Size * Block_Size;

  logic             ic_read;
  logic [31:0]      ic_Addr;
  logic [BLK_W-1:0] ic_Data;
  logic             ic_ready;

  logic             dc_read;
  logic             dc_write;
  logic [31:0]      dc_Addr;
  logic [BLK_W-1:0] dc_Wdata;
  logic [BLK_W-1:0] dc_Rdata;
  logic             dc_ready;

  logic [31:0]      Addr_Mem;
  logic             read_Mem;
  logic             write_Mem;
  logic [BLK_W-1:0] Data_Mem_wr;
  logic [BLK_W-1:0] Data_Mem_rd;
  logic             ready_mem;

  logic             busy;

  modport slave (
    input  ic_read, ic_Addr, dc_read, dc_write, dc_Addr, dc_Wdata,
           Data_Mem_rd, ready_mem,
    output ic_Data, ic_ready, dc_Rdata, dc_ready,
           Addr_Mem, read_Mem, write_Mem, Data_Mem_wr, busy
  );

  modport master (
    output ic_read, ic_Addr, dc_read, dc_write, dc_Addr, dc_Wdata,
           Data_Mem_rd, ready_mem,
    input  ic_Data, ic_ready, dc_Rdata, dc_ready,
           Addr_Mem, read_Mem, write_Mem, Data_Mem_wr, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one main-memory block port between the instruction cache
//   (read-only) and the data cache (read/write). One request is latched at a
//   time, issued to memory, and completed with a one-cycle ready pulse to the
//   requester, followed by a one-cycle gap so the requester can drop its level.
//   Ports:
//     clk   - clock, rising edge
//     reset - synchronous, active-low
//     bus   - mem_arbiter_if.slave (cache channels, memory port, busy)
//   Configuration macro ROUND_ROBIN_EN:
//     defined   - contested arbitrations alternate, starting with the D-cache
//     undefined - the D-cache always wins a contested arbitration
module mem_arbiter #(
  parameter int Word_Size  = 32,
  parameter int Block_Size = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int BLK_W = Word_Size * Block_Size;
  // Clears the byte-within-block offset bits of an address.
  localparam logic [31:0] ADDR_MASK = ~(32'(BLK_W / 8) - 32'd1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_MEM, RESP, GAP} state_t;

  state_t           state_q, state_d;
  logic             sel_dc_q, sel_dc_d;     // 1: current access belongs to D-cache
  logic             op_wr_q, op_wr_d;       // 1: current access is a write
  logic [31:0]      addr_q, addr_d;         // block-aligned latched address
  logic [BLK_W-1:0] wdata_q, wdata_d;
  logic [BLK_W-1:0] ic_data_q, ic_data_d;
  logic [BLK_W-1:0] dc_rdata_q, dc_rdata_d;
`ifdef ROUND_ROBIN_EN
  logic             last_dc_q, last_dc_d;   // winner of last contested grant
`endif

  logic ic_req;
  logic dc_req;
  logic grant_dc;

  always_comb begin
    state_d    = state_q;
    sel_dc_d   = sel_dc_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_data_d  = ic_data_q;
    dc_rdata_d = dc_rdata_q;
`ifdef ROUND_ROBIN_EN
    last_dc_d  = last_dc_q;
`endif
    ic_req = bus.ic_read;
    dc_req = bus.dc_read | bus.dc_write;

`ifdef ROUND_ROBIN_EN
    // Only a contested arbitration consults or updates the history, so the
    // loser's follow-up lone grant does not flip the next tie-break.
    if (ic_req && dc_req) grant_dc = ~last_dc_q;
    else                  grant_dc = dc_req;
`else
    grant_dc = dc_req;
`endif

    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          sel_dc_d = grant_dc;
          // read+write together from the D-cache is performed as a write
          op_wr_d  = grant_dc & bus.dc_write;
          addr_d   = (grant_dc ? bus.dc_Addr : bus.ic_Addr) & ADDR_MASK;
          wdata_d  = bus.dc_Wdata;
`ifdef ROUND_ROBIN_EN
          if (ic_req && dc_req) last_dc_d = grant_dc;
`endif
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_MEM;
      WAIT_MEM: begin
        if (bus.ready_mem) begin
          if (!op_wr_q) begin
            if (sel_dc_q) dc_rdata_d = bus.Data_Mem_rd;
            else          ic_data_d  = bus.Data_Mem_rd;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_dc_q   <= 1'b0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_data_q  <= '0;
      dc_rdata_q <= '0;
`ifdef ROUND_ROBIN_EN
      last_dc_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_dc_q   <= sel_dc_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_data_q  <= ic_data_d;
      dc_rdata_q <= dc_rdata_d;
`ifdef ROUND_ROBIN_EN
      last_dc_q  <= last_dc_d;
`endif
    end
  end

  // Strobes are held from ISSUE through WAIT_MEM and drop on entry to RESP.
  assign bus.read_Mem    = ((state_q == ISSUE) || (state_q == WAIT_MEM)) && !op_wr_q;
  assign bus.write_Mem   = ((state_q == ISSUE) || (state_q == WAIT_MEM)) &&  op_wr_q;
  assign bus.Addr_Mem    = addr_q;
  assign bus.Data_Mem_wr = wdata_q;
  assign bus.ic_Data     = ic_data_q;
  assign bus.dc_Rdata    = dc_rdata_q;
  assign bus.ic_ready    = (state_q == RESP) && !sel_dc_q;
  assign bus.dc_ready    = (state_q == RESP) &&  sel_dc_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int B  = 4;
  localparam int BW = W * B;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.Word_Size(W), .Block_Size(B)) bus ();
  mem_arbiter #(.Word_Size(W), .Block_Size(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: pending requests, expected cache-side data, tie history.
  bit          m_ic_pend, m_dc_pend, m_dc_wr, m_last_dc;
  logic [31:0] m_ic_addr, m_dc_addr;
  logic [BW-1:0] m_dc_wdata, m_ic_data, m_dc_data;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ic_pend = 0; m_dc_pend = 0; m_dc_wr = 0; m_last_dc = 0;
    m_ic_data = '0; m_dc_data = '0;
  endtask

  task automatic raise(input bit ic, input bit dr, input bit dw,
                       input logic [31:0] ia, input logic [31:0] da, input logic [BW-1:0] wd);
    if (ic && !m_ic_pend) begin
      bus.ic_read = 1'b1; bus.ic_Addr = ia;
      m_ic_pend = 1; m_ic_addr = ia;
    end
    if ((dr || dw) && !m_dc_pend) begin
      bus.dc_read = dr; bus.dc_write = dw; bus.dc_Addr = da; bus.dc_Wdata = wd;
      m_dc_pend = 1; m_dc_wr = dw; m_dc_addr = da; m_dc_wdata = wd;
    end
  endtask

  // Called in an IDLE cycle with at least one request pending; runs one
  // complete access and returns in the following IDLE cycle.
  task automatic serve_one(input int lat, input logic [BW-1:0] rdata, input bit spurious);
    bit w_dc, w_wr;
    logic [31:0] a;
    int k;
    if (m_ic_pend && m_dc_pend) begin
`ifdef ROUND_ROBIN_EN
      w_dc = !m_last_dc;
`else
      w_dc = 1'b1;
`endif
      m_last_dc = w_dc;
    end else begin
      w_dc = m_dc_pend;
    end
    w_wr = w_dc && m_dc_wr;
    a = (w_dc ? m_dc_addr : m_ic_addr) & 32'hFFFF_FFF0;

    check_val("idle_busy", 128'(bus.busy), 128'(0));
    k = 0;
    while (!(bus.read_Mem || bus.write_Mem) && k < 8) begin
      tick();
      k++;
    end
    check_val("issue_latency", 128'(k), 128'(1));
    check_val("addr_mem", 128'(bus.Addr_Mem), 128'(a));
    check_val("read_mem", 128'(bus.read_Mem), 128'(!w_wr));
    check_val("write_mem", 128'(bus.write_Mem), 128'(w_wr));
    if (w_wr) check_val("data_mem_wr", bus.Data_Mem_wr, m_dc_wdata);

    // Winner's inputs change after the latch; the access must not follow them.
    if (w_dc) begin
      bus.dc_Addr = $urandom(); bus.dc_Wdata = rand128();
    end else begin
      bus.ic_Addr = $urandom();
    end
    // Optional ready_mem while still in the issue cycle: must be ignored.
    if (spurious) begin
      bus.ready_mem = 1'b1; bus.Data_Mem_rd = rand128();
    end

    for (int j = 0; j < lat; j++) begin
      tick();
      bus.ready_mem = 1'b0;
      check_val("strobe_hold", 128'({bus.read_Mem, bus.write_Mem}), 128'({!w_wr, w_wr}));
      check_val("addr_hold", 128'(bus.Addr_Mem), 128'(a));
      check_val("early_ready", 128'({bus.ic_ready, bus.dc_ready}), 128'(0));
    end

    bus.ready_mem = 1'b1; bus.Data_Mem_rd = rdata;
    tick();
    bus.ready_mem = 1'b0; bus.Data_Mem_rd = rand128();
    if (!w_wr) begin
      if (w_dc) m_dc_data = rdata;
      else      m_ic_data = rdata;
    end
    check_val("resp_strobe_drop", 128'({bus.read_Mem, bus.write_Mem}), 128'(0));
    check_val("ic_ready", 128'(bus.ic_ready), 128'(!w_dc));
    check_val("dc_ready", 128'(bus.dc_ready), 128'(w_dc));
    check_val("ic_data", bus.ic_Data, m_ic_data);
    check_val("dc_rdata", bus.dc_Rdata, m_dc_data);

    if (w_dc) begin
      bus.dc_read = 1'b0; bus.dc_write = 1'b0; m_dc_pend = 0;
    end else begin
      bus.ic_read = 1'b0; m_ic_pend = 0;
    end
    tick();
    check_val("gap_no_ready", 128'({bus.ic_ready, bus.dc_ready}), 128'(0));
    check_val("gap_busy", 128'(bus.busy), 128'(1));
    tick();
    check_val("back_idle", 128'(bus.busy), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ic;
    int dop;
    // Reset with every request asserted.
    reset = 1'b0;
    bus.ic_read = 1'b1; bus.ic_Addr = 32'h1111_1111;
    bus.dc_read = 1'b1; bus.dc_write = 1'b1; bus.dc_Addr = 32'h2222_2222;
    bus.dc_Wdata = rand128(); bus.ready_mem = 1'b0; bus.Data_Mem_rd = '0;
    model_reset();
    tick();
    tick();
    check_val("rst_busy", 128'(bus.busy), 128'(0));
    check_val("rst_strobes", 128'({bus.read_Mem, bus.write_Mem}), 128'(0));
    check_val("rst_ready", 128'({bus.ic_ready, bus.dc_ready}), 128'(0));
    check_val("rst_addr", 128'(bus.Addr_Mem), 128'(0));
    check_val("rst_wdata", bus.Data_Mem_wr, 128'(0));
    check_val("rst_ic_data", bus.ic_Data, 128'(0));
    check_val("rst_dc_rdata", bus.dc_Rdata, 128'(0));
    bus.ic_read = 1'b0; bus.dc_read = 1'b0; bus.dc_write = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Lone I-cache read, memory answers 3 cycles after the strobe.
    raise(1, 0, 0, 32'h0000_1234, 32'h0, '0);
    serve_one(3, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF, 0);

    // Two simultaneous pairs.
    raise(1, 1, 0, 32'h0000_0100, 32'h0000_0200, '0);
    serve_one(2, rand128(), 0);
    serve_one(2, rand128(), 0);
    raise(1, 1, 0, 32'h0000_0100, 32'h0000_0200, '0);
    serve_one(1, rand128(), 0);
    serve_one(1, rand128(), 0);

    // D-cache write; dc_Rdata must keep its previous value.
    raise(0, 0, 1, 32'h0, 32'h0000_0040, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
    serve_one(2, rand128(), 0);

    // Read and write together is a write.
    raise(0, 1, 1, 32'h0, 32'h0000_0080, rand128());
    serve_one(2, rand128(), 1);

    // Reset during WAIT_MEM, late ready_mem after release.
    raise(0, 1, 0, 32'h0, 32'h0000_0300, '0);
    tick();
    check_val("r5_strobe", 128'(bus.read_Mem), 128'(1));
    tick();
    reset = 1'b0; bus.dc_read = 1'b0;
    tick();
    model_reset();
    check_val("r5_strobes_drop", 128'({bus.read_Mem, bus.write_Mem}), 128'(0));
    check_val("r5_busy", 128'(bus.busy), 128'(0));
    check_val("r5_ready", 128'({bus.ic_ready, bus.dc_ready}), 128'(0));
    reset = 1'b1; bus.ready_mem = 1'b1; bus.Data_Mem_rd = rand128();
    tick();
    bus.ready_mem = 1'b0;
    check_val("r5_late_ready", 128'({bus.ic_ready, bus.dc_ready}), 128'(0));
    check_val("r5_late_busy", 128'(bus.busy), 128'(0));
    check_val("r5_dc_rdata", bus.dc_Rdata, m_dc_data);
    tick();
    check_val("r5_after_ready", 128'({bus.ic_ready, bus.dc_ready}), 128'(0));

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      ic  = 1'($urandom_range(0, 1));
      dop = int'($urandom_range(0, 3));
      if (!ic && dop == 0) ic = 1'b1;
      raise(ic, dop[0], dop[1], $urandom(), $urandom(), rand128());
      while (m_ic_pend || m_dc_pend)
        serve_one(int'($urandom_range(1, 4)), rand128(), $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
